// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down-counter and its 4-bit slices.
//   SLICE_W        : width of one counting slice
//   DEFAULT_WIDTH  : default counter width
//   nibble_is_zero : zero detect for one slice, used for the borrow chain
package down_counter_pkg;

  localparam int unsigned SLICE_W       = 4;
  localparam int unsigned DEFAULT_WIDTH = 16;

  function automatic logic nibble_is_zero(input logic [SLICE_W-1:0] nib);
    return (nib == '0);
  endfunction

endpackage

// File: rtl/down_counter16_if.sv
// Control/data bundle of the down-counter.
//   nCLR, nLOAD : synchronous clear / load, active-low
//   ENP, ENT    : parallel / trickle count enables
//   AUTO        : auto-reload at zero when 1, wrap when 0
//   Din         : load value
//   Dout        : current count
//   RCO         : combinational borrow out (ENT & count==0)
//   TC          : registered pulse for a count event taken at zero
interface down_counter16_if
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             nCLR;
  logic             nLOAD;
  logic             ENP;
  logic             ENT;
  logic             AUTO;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Dout;
  logic             RCO;
  logic             TC;

  modport master (
    output nCLR, nLOAD, ENP, ENT, AUTO, Din,
    input  Dout, RCO, TC
  );

  modport slave (
    input  nCLR, nLOAD, ENP, ENT, AUTO, Din,
    output Dout, RCO, TC
  );

endinterface

// File: rtl/down4_slice.sv
// One 4-bit down-counting slice with look-ahead borrow.
//   CLK, RST : clock, async active-high reset
//   nCLR     : synchronous clear (highest priority), active-low
//   nLOAD    : synchronous load of LD, active-low
//   ENP, ENT : count enables; both high decrements Q
//   Q        : slice count
//   BO       : borrow out = ENT & (Q==0), feeds the next slice's ENT
module down4_slice
  import down_counter_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               nCLR,
  input  logic               nLOAD,
  input  logic [SLICE_W-1:0] LD,
  input  logic               ENP,
  input  logic               ENT,
  output logic [SLICE_W-1:0] Q,
  output logic               BO
);

  logic [SLICE_W-1:0] q_q;
  logic [SLICE_W-1:0] q_d;

  // Next count: clear, load, decrement, hold in priority order
  always_comb begin
    q_d = q_q;
    if (!nCLR) begin
      q_d = '0;
    end else if (!nLOAD) begin
      q_d = LD;
    end else if (ENP && ENT) begin
      q_d = q_q - SLICE_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign BO = ENT & nibble_is_zero(q_q);

endmodule

// File: rtl/down_counter16.sv
// Loadable down-counter built from cascaded 4-bit slices, with one-shot
// (wrap) and auto-reload modes.
//   CLK, RST : clock, async active-high reset
//   bus      : control/data bundle (slave side), see down_counter16_if
// WIDTH must be a multiple of SLICE_W.
module down_counter16
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic              CLK,
  input logic              RST,
  down_counter16_if.slave  bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;

  logic [NSLICE:0]  ent_chain;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] ld_c;
  logic [WIDTH-1:0] rld_q;
  logic [WIDTH-1:0] rld_d;
  logic             tc_q;
  logic             tc_d;
  logic             count_c;
  logic             zero_evt_c;
  logic             reload_c;
  logic             slice_nload_c;

  // Borrow chain: slice k counts only when every lower slice is zero
  assign ent_chain[0] = bus.ENT;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    down4_slice u_slice (
      .CLK   (CLK),
      .RST   (RST),
      .nCLR  (bus.nCLR),
      .nLOAD (slice_nload_c),
      .LD    (ld_c[k*SLICE_W +: SLICE_W]),
      .ENP   (bus.ENP),
      .ENT   (ent_chain[k]),
      .Q     (cnt[k*SLICE_W +: SLICE_W]),
      .BO    (ent_chain[k+1])
    );
  end

  // A count event at zero either reloads from RLD or lets the slices wrap
  assign count_c       = bus.ENP & bus.ENT;
  assign zero_evt_c    = count_c & ent_chain[NSLICE];
  assign reload_c      = zero_evt_c & bus.AUTO;
  assign slice_nload_c = bus.nLOAD & ~reload_c;
  assign ld_c          = (!bus.nLOAD) ? bus.Din : rld_q;

  // Reload register and terminal-count pulse
  always_comb begin
    rld_d = rld_q;
    tc_d  = 1'b0;
    if (bus.nCLR) begin
      if (!bus.nLOAD) begin
        rld_d = bus.Din;
      end else begin
        tc_d = zero_evt_c;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rld_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      rld_q <= rld_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.Dout = cnt;
  assign bus.RCO  = ent_chain[NSLICE];
  assign bus.TC   = tc_q;

endmodule
